// File: rtl/riscv_sort_soc.sv
// Single-cycle RV32I-subset core with a combinational program ROM and a word RAM.
// The ROM program stores 4,5,3,1,2 at ARRAY_BASE, bubble-sorts it in place, then halts.

package riscv_sort_pkg;
  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // Branch/jump offsets are passed in halfwords because bit 0 is never encoded.
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPC_STORE};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:1] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OPC_OP};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:1] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
  endfunction
endpackage

module instruction_memory #(
  parameter int          IMEM_WORDS = 256,
  parameter logic [31:0] ARRAY_BASE = 32'h0000_0100
) (
  input  logic [31:0] i_pc,
  output logic [31:0] o_instruction
);
  import riscv_sort_pkg::*;

  localparam int PROG_LEN = 29;
  // x8 base, x5 outer i, x6 limit, x7 inner j, x14 inner limit, x9/x10 a[j]/a[j+1], x15 address
  localparam logic [31:0] PROGRAM [PROG_LEN] = '{
    enc_i(ARRAY_BASE[11:0], 5'd0, 3'b000, 5'd8, OPC_OP_IMM),
    enc_i(12'd4, 5'd0, 3'b000, 5'd9,  OPC_OP_IMM),
    enc_i(12'd5, 5'd0, 3'b000, 5'd10, OPC_OP_IMM),
    enc_i(12'd3, 5'd0, 3'b000, 5'd11, OPC_OP_IMM),
    enc_i(12'd1, 5'd0, 3'b000, 5'd12, OPC_OP_IMM),
    enc_i(12'd2, 5'd0, 3'b000, 5'd13, OPC_OP_IMM),
    enc_s(12'd0,  5'd9,  5'd8),
    enc_s(12'd4,  5'd10, 5'd8),
    enc_s(12'd8,  5'd11, 5'd8),
    enc_s(12'd12, 5'd12, 5'd8),
    enc_s(12'd16, 5'd13, 5'd8),
    enc_i(12'd4, 5'd0, 3'b000, 5'd6, OPC_OP_IMM),
    enc_i(12'd0, 5'd0, 3'b000, 5'd5, OPC_OP_IMM),
    enc_b(12'h01E, 5'd6, 5'd5, 3'b101),
    enc_i(12'd0, 5'd0, 3'b000, 5'd7, OPC_OP_IMM),
    enc_r(7'h20, 5'd5, 5'd6, 3'b000, 5'd14),
    enc_b(12'h014, 5'd14, 5'd7, 3'b101),
    enc_i(12'd2, 5'd7, 3'b001, 5'd15, OPC_OP_IMM),
    enc_r(7'h00, 5'd8, 5'd15, 3'b000, 5'd15),
    enc_i(12'd0, 5'd15, 3'b010, 5'd9,  OPC_LOAD),
    enc_i(12'd4, 5'd15, 3'b010, 5'd10, OPC_LOAD),
    enc_b(12'h006, 5'd9, 5'd10, 3'b101),
    enc_s(12'd0, 5'd10, 5'd15),
    enc_s(12'd4, 5'd9,  5'd15),
    enc_i(12'd1, 5'd7, 3'b000, 5'd7, OPC_OP_IMM),
    enc_j(20'hFFFEE, 5'd0),
    enc_i(12'd1, 5'd5, 3'b000, 5'd5, OPC_OP_IMM),
    enc_j(20'hFFFE4, 5'd0),
    enc_j(20'h00000, 5'd0)
  };

  logic [29:0] w_idx;
  logic        w_unused_lsb;
  assign w_idx        = i_pc[31:2];
  assign w_unused_lsb = ^i_pc[1:0];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    o_instruction = NOP;
    if (w_idx < 30'(IMEM_WORDS) && w_idx < 30'(PROG_LEN)) o_instruction = PROGRAM[w_idx[4:0]];
  end
endmodule

module data_memory #(
  parameter int DMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data
);
  localparam int AW = $clog2(DMEM_WORDS);

  logic [31:0] dmem [DMEM_WORDS];
  logic        w_in_range;
  logic        w_unused_lsb;
  assign w_in_range   = address[31:2] < 30'(DMEM_WORDS);
  assign w_unused_lsb = ^address[1:0];
  assign read_data    = (mem_read && w_in_range) ? dmem[address[AW+1:2]] : '0;

  // NOTE: RAM has no reset so it maps onto block memory; data survives a core reset.
  always_ff @(posedge clk) begin
    if (mem_write && w_in_range) dmem[address[AW+1:2]] <= write_data;
  end
endmodule

module register_file (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_we,
  input  logic [4:0]  i_rd,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  output logic [31:0] o_rs1_data,
  output logic [31:0] o_rs2_data
);
  logic [31:0] registers [32];

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) registers[i] <= '0;
    end else if (i_we && i_rd != 5'd0) begin
      registers[i_rd] <= i_wdata;
    end
  end

  assign o_rs1_data = (i_rs1 == 5'd0) ? '0 : registers[i_rs1];
  assign o_rs2_data = (i_rs2 == 5'd0) ? '0 : registers[i_rs2];
endmodule

module risc_v_cpu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_instruction,
  input  logic [31:0] i_dmem_rdata,
  output logic [31:0] o_pc,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic        o_dmem_we
);
  import riscv_sort_pkg::*;

  logic [31:0] r_pc;
  opcode_e     w_opcode;
  logic [2:0]  w_f3, w_alu_f3;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [31:0] w_rs1_data, w_rs2_data, w_op_a, w_op_b, w_alu, w_next_pc, w_rd_data;
  logic        w_alu_alt, w_taken, w_rd_we, w_store;

  assign w_opcode = opcode_e'(i_instruction[6:0]);
  assign w_rd     = i_instruction[11:7];
  assign w_f3     = i_instruction[14:12];
  assign w_rs1    = i_instruction[19:15];
  assign w_rs2    = i_instruction[24:20];
  assign w_imm_i  = {{20{i_instruction[31]}}, i_instruction[31:20]};
  assign w_imm_s  = {{20{i_instruction[31]}}, i_instruction[31:25], i_instruction[11:7]};
  assign w_imm_b  = {{19{i_instruction[31]}}, i_instruction[31], i_instruction[7],
                     i_instruction[30:25], i_instruction[11:8], 1'b0};
  assign w_imm_u  = {i_instruction[31:12], 12'b0};
  assign w_imm_j  = {{11{i_instruction[31]}}, i_instruction[31], i_instruction[19:12],
                     i_instruction[20], i_instruction[30:21], 1'b0};

  register_file reg_file (
    .clk(clk), .rst(rst), .i_we(w_rd_we), .i_rd(w_rd), .i_wdata(w_rd_data),
    .i_rs1(w_rs1), .i_rs2(w_rs2), .o_rs1_data(w_rs1_data), .o_rs2_data(w_rs2_data)
  );

  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] f3, input logic alt);
    logic [31:0] res;
    res = a + b;
    case (f3)
      3'b000: res = alt ? a - b : a + b;
      3'b001: res = a << b[4:0];
      3'b010: res = {31'b0, $signed(a) < $signed(b)};
      3'b011: res = {31'b0, a < b};
      3'b100: res = a ^ b;
      3'b101: res = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'b110: res = a | b;
      3'b111: res = a & b;
    endcase
    return res;
  endfunction

  // Loads, stores and JALR all reuse the ALU as an rs1 + immediate adder.
  always_comb begin
    w_op_a    = w_rs1_data;
    w_op_b    = w_imm_i;
    w_alu_f3  = 3'b000;
    w_alu_alt = 1'b0;
    case (w_opcode)
      OPC_OP:     begin w_op_b = w_rs2_data; w_alu_f3 = w_f3; w_alu_alt = i_instruction[30]; end
      OPC_OP_IMM: begin w_alu_f3 = w_f3; w_alu_alt = (w_f3 == 3'b101) && i_instruction[30]; end
      OPC_STORE:  w_op_b = w_imm_s;
      OPC_AUIPC:  begin w_op_a = r_pc; w_op_b = w_imm_u; end
      default:    ;
    endcase
  end
  assign w_alu = alu(w_op_a, w_op_b, w_alu_f3, w_alu_alt);

  always_comb begin
    w_taken = 1'b0;
    case (w_f3)
      3'b000:  w_taken = w_rs1_data == w_rs2_data;
      3'b001:  w_taken = w_rs1_data != w_rs2_data;
      3'b100:  w_taken = $signed(w_rs1_data) <  $signed(w_rs2_data);
      3'b101:  w_taken = $signed(w_rs1_data) >= $signed(w_rs2_data);
      3'b110:  w_taken = w_rs1_data <  w_rs2_data;
      3'b111:  w_taken = w_rs1_data >= w_rs2_data;
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_next_pc = r_pc + 32'd4;
    w_rd_we   = 1'b0;
    w_rd_data = w_alu;
    w_store   = 1'b0;
    case (w_opcode)
      OPC_LUI:                    begin w_rd_we = 1'b1; w_rd_data = w_imm_u; end
      OPC_AUIPC, OPC_OP_IMM, OPC_OP: w_rd_we = 1'b1;
      OPC_LOAD:                   begin w_rd_we = 1'b1; w_rd_data = i_dmem_rdata; end
      OPC_STORE:                  w_store = 1'b1;
      OPC_BRANCH:                 if (w_taken) w_next_pc = r_pc + w_imm_b;
      OPC_JAL:                    begin w_rd_we = 1'b1; w_rd_data = r_pc + 32'd4; w_next_pc = r_pc + w_imm_j; end
      OPC_JALR:                   begin w_rd_we = 1'b1; w_rd_data = r_pc + 32'd4; w_next_pc = {w_alu[31:1], 1'b0}; end
      default:                    ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pc <= RESET_PC;
    else     r_pc <= w_next_pc;
  end

  assign o_pc         = r_pc;
  assign o_dmem_addr  = w_alu;
  assign o_dmem_wdata = w_rs2_data;
  assign o_dmem_we    = w_store && !rst;
endmodule

module riscv_sort_soc #(
  parameter int          IMEM_WORDS = 256,
  parameter int          DMEM_WORDS = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] ARRAY_BASE = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] debug_pc,
  output logic [31:0] debug_instruction,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        dmem_we
);
  logic [31:0] w_rdata;

  risc_v_cpu #(.RESET_PC(RESET_PC)) u_cpu (
    .clk(clk), .rst(rst), .i_instruction(debug_instruction), .i_dmem_rdata(w_rdata),
    .o_pc(debug_pc), .o_dmem_addr(dmem_addr), .o_dmem_wdata(dmem_wdata), .o_dmem_we(dmem_we)
  );

  instruction_memory #(.IMEM_WORDS(IMEM_WORDS), .ARRAY_BASE(ARRAY_BASE)) u_imem (
    .i_pc(debug_pc), .o_instruction(debug_instruction)
  );

  data_memory #(.DMEM_WORDS(DMEM_WORDS)) u_dmem (
    .clk(clk), .mem_read(1'b1), .mem_write(dmem_we), .address(dmem_addr),
    .write_data(dmem_wdata), .read_data(w_rdata)
  );
endmodule

// File: tb/tb_riscv_sort_soc.sv
// Bench for riscv_sort_soc: runs the sort program (with a mid-run reset), then drives a
// standalone core with a directed instruction table and probes the ROM directly.
module tb_riscv_sort_soc;
  logic        clk, rst;
  logic [31:0] debug_pc, debug_instruction, dmem_addr, dmem_wdata;
  logic        dmem_we;

  logic        core_rst, core_we;
  logic [31:0] core_instr, core_pc, core_addr, core_wdata, core_rdata;
  logic [31:0] im_pc, im_instr;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit tracing  = 0;
  logic [31:0] tr_addr[$], tr_data[$];
  int          tr_cyc[$];

  riscv_sort_soc dut (
    .clk(clk), .rst(rst), .debug_pc(debug_pc), .debug_instruction(debug_instruction),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we)
  );

  risc_v_cpu u_core (
    .clk(clk), .rst(core_rst), .i_instruction(core_instr), .i_dmem_rdata(core_rdata),
    .o_pc(core_pc), .o_dmem_addr(core_addr), .o_dmem_wdata(core_wdata), .o_dmem_we(core_we)
  );

  data_memory u_dm (
    .clk(clk), .mem_read(1'b1), .mem_write(core_we), .address(core_addr),
    .write_data(core_wdata), .read_data(core_rdata)
  );

  instruction_memory u_im (.i_pc(im_pc), .o_instruction(im_instr));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tracing && dmem_we) begin
      tr_addr.push_back(dmem_addr);
      tr_data.push_back(dmem_wdata);
      tr_cyc.push_back(cyc);
    end
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, actual, expected);
  endtask

  function automatic logic [31:0] e_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] e_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] e_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] e_b(input logic [12:1] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                      input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] e_j(input logic [20:1] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction
  function automatic logic [31:0] e_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] exp_rd;
    logic [31:0] exp_pc;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] exp;
  } im_vec_t;

  // Run the SoC until the halt address; false if the budget expires.
  task automatic wait_halt(input int budget, output bit reached);
    reached = 0;
    for (int i = 0; i < budget && !reached; i++) begin
      @(posedge clk); #1;
      if (debug_pc == 32'h70) reached = 1;
    end
  endtask

  task automatic check_sorted(input string tag);
    for (int k = 0; k < 5; k++)
      check($sformatf("%s_a%0d", tag, k), dut.u_dmem.dmem[64 + k], 32'(k + 1));
  endtask

  vec_t        vecs[24];
  im_vec_t     ims[7];
  logic [31:0] snap[256];

  initial begin
    bit reached;
    int bad, regs_nz;

    vecs[0]  = '{e_i(12'd7,   5'd0,  3'b000, 5'd9,  7'h13), 5'd9,  32'd7,          32'h04};
    vecs[1]  = '{e_i(12'd5,   5'd0,  3'b000, 5'd0,  7'h13), 5'd0,  32'd0,          32'h08};
    vecs[2]  = '{e_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd9),       5'd9,  32'd0,          32'h0C};
    vecs[3]  = '{e_i(12'hFFF, 5'd0,  3'b000, 5'd10, 7'h13), 5'd10, 32'hFFFF_FFFF,  32'h10};
    vecs[4]  = '{e_r(7'h00, 5'd10, 5'd0, 3'b011, 5'd11),     5'd11, 32'd1,          32'h14};
    vecs[5]  = '{e_i(12'd1,   5'd0,  3'b000, 5'd12, 7'h13), 5'd12, 32'd1,          32'h18};
    vecs[6]  = '{e_b(12'h010, 5'd12, 5'd10, 3'b100),         5'd10, 32'hFFFF_FFFF,  32'h38};
    vecs[7]  = '{e_b(12'h010, 5'd12, 5'd10, 3'b110),         5'd12, 32'd1,          32'h3C};
    vecs[8]  = '{e_j(20'h00080, 5'd13),                      5'd13, 32'h40,         32'h13C};
    vecs[9]  = '{e_i(12'h091, 5'd0,  3'b000, 5'd14, 7'h13), 5'd14, 32'h91,         32'h140};
    vecs[10] = '{e_i(12'h000, 5'd14, 3'b000, 5'd15, 7'h67), 5'd15, 32'h144,        32'h90};
    vecs[11] = '{e_i(12'd9,   5'd0,  3'b000, 5'd16, 7'h13), 5'd16, 32'd9,          32'h94};
    vecs[12] = '{e_s(12'h400, 5'd10, 5'd0),                  5'd16, 32'd9,          32'h98};
    vecs[13] = '{e_i(12'h400, 5'd0,  3'b010, 5'd16, 7'h03), 5'd16, 32'd0,          32'h9C};
    vecs[14] = '{e_s(12'h008, 5'd10, 5'd0),                  5'd16, 32'd0,          32'hA0};
    vecs[15] = '{e_i(12'h008, 5'd0,  3'b010, 5'd17, 7'h03), 5'd17, 32'hFFFF_FFFF,  32'hA4};
    vecs[16] = '{e_i({7'h00, 5'd28}, 5'd10, 3'b101, 5'd18, 7'h13), 5'd18, 32'h0000_000F, 32'hA8};
    vecs[17] = '{e_i({7'h20, 5'd28}, 5'd10, 3'b101, 5'd19, 7'h13), 5'd19, 32'hFFFF_FFFF, 32'hAC};
    vecs[18] = '{e_r(7'h20, 5'd12, 5'd0, 3'b000, 5'd20),     5'd20, 32'hFFFF_FFFF,  32'hB0};
    vecs[19] = '{e_u(20'h12345, 5'd21, 7'h37),               5'd21, 32'h1234_5000,  32'hB4};
    vecs[20] = '{e_u(20'h00001, 5'd22, 7'h17),               5'd22, 32'h0000_10B4,  32'hB8};
    vecs[21] = '{32'h0000_0B0B,                              5'd22, 32'h0000_10B4,  32'hBC};
    vecs[22] = '{e_i(12'd33,  5'd0,  3'b000, 5'd24, 7'h13), 5'd24, 32'd33,         32'hC0};
    vecs[23] = '{e_r(7'h00, 5'd24, 5'd12, 3'b001, 5'd23),    5'd23, 32'd2,          32'hC4};

    ims[0] = '{32'h0000_0000, 32'h1000_0413};
    ims[1] = '{32'h0000_0002, 32'h1000_0413};
    ims[2] = '{32'h0000_0018, 32'h0094_2023};
    ims[3] = '{32'h0000_0070, 32'h0000_006F};
    ims[4] = '{32'h0000_0074, 32'h0000_0013};
    ims[5] = '{32'h0000_0400, 32'h0000_0013};
    ims[6] = '{32'hFFFF_FFFC, 32'h0000_0013};

    rst = 1'b1; core_rst = 1'b1; core_instr = 32'h13; im_pc = '0;

    // Reset state after 20 ns of reset
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("reset_pc", debug_pc, 32'h0);
    check("reset_we", {31'b0, dmem_we}, 32'h0);
    regs_nz = 0;
    for (int r = 0; r < 32; r++) if (dut.u_cpu.reg_file.registers[r] !== 32'h0) regs_nz++;
    check("reset_regs_nonzero", 32'(regs_nz), 32'h0);

    // Full program run with store trace
    tracing = 1;
    rst = 1'b0;
    #1;
    check("first_instr", debug_instruction, 32'h1000_0413);
    wait_halt(400, reached);
    check("halt_within_400", {31'b0, reached}, 32'h1);
    repeat (20) @(posedge clk);
    #1;
    check("halt_pc_stuck", debug_pc, 32'h70);
    tracing = 0;
    check_sorted("run1");
    check("x8_base", dut.u_cpu.reg_file.registers[8], 32'h100);
    check("x5_outer_end", dut.u_cpu.reg_file.registers[5], 32'd4);
    check("x6_limit", dut.u_cpu.reg_file.registers[6], 32'd4);

    check("store_count", 32'(tr_addr.size()), 32'd21);
    for (int k = 0; k < 5 && k < tr_addr.size(); k++) begin
      check($sformatf("init_store%0d_addr", k), tr_addr[k], 32'h100 + 32'(4 * k));
      check($sformatf("init_store%0d_cycle", k), 32'(tr_cyc[k] - tr_cyc[0]), 32'(k));
    end
    if (tr_data.size() >= 5) begin
      check("init_store0_data", tr_data[0], 32'd4);
      check("init_store1_data", tr_data[1], 32'd5);
      check("init_store2_data", tr_data[2], 32'd3);
      check("init_store3_data", tr_data[3], 32'd1);
      check("init_store4_data", tr_data[4], 32'd2);
    end
    bad = 0;
    for (int k = 5; k < tr_addr.size(); k++)
      if (tr_addr[k] < 32'h100 || tr_addr[k] > 32'h110 || tr_addr[k][1:0] != 2'b00) bad++;
    check("swap_store_range_bad", 32'(bad), 32'd0);

    // Reset in the middle of the sort: restart at once, RAM keeps partial data
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (60) @(posedge clk);
    @(negedge clk);
    check("midrun_pc_not_halted", {31'b0, debug_pc != 32'h70}, 32'h1);
    rst = 1'b1;
    #1;
    check("midrun_reset_pc", debug_pc, 32'h0);
    check("midrun_reset_we", {31'b0, dmem_we}, 32'h0);
    check("midrun_reset_x8", dut.u_cpu.reg_file.registers[8], 32'h0);
    check("midrun_ram_kept", {31'b0, dut.u_dmem.dmem[64] != 32'h0}, 32'h1);
    @(negedge clk); rst = 1'b0;
    wait_halt(400, reached);
    check("rerun_halt", {31'b0, reached}, 32'h1);
    check_sorted("run2");

    // ROM reads, including ignored low bits and fetch past the end
    for (int k = 0; k < 7; k++) begin
      im_pc = ims[k].pc;
      #1;
      check($sformatf("rom_%h", ims[k].pc), im_instr, ims[k].exp);
    end

    // Directed instruction table on the standalone core
    @(negedge clk); core_rst = 1'b0;
    for (int i = 0; i < 24; i++) begin
      core_instr = vecs[i].instr;
      if (i == 12) for (int k = 0; k < 256; k++) snap[k] = u_dm.dmem[k];
      @(posedge clk); #1;
      check($sformatf("vec%0d_rd", i), u_core.reg_file.registers[vecs[i].rd], vecs[i].exp_rd);
      check($sformatf("vec%0d_pc", i), core_pc, vecs[i].exp_pc);
      if (i == 12) begin
        bad = 0;
        for (int k = 0; k < 256; k++) if (u_dm.dmem[k] !== snap[k]) bad++;
        check("sw_oob_changed_words", 32'(bad), 32'd0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
